// File: rtl/otter_decode_stage.sv
// OTTER decode stage: registered decode of one RV32 instruction per accept, with a
// valid/ready handshake and interrupt slot insertion. Optional macro OTTER_MDU_EN adds M-extension ALU codes.
module otter_decode_stage #(
    parameter int N_INT = 4,
`ifdef OTTER_MDU_EN
    parameter int ALU_FUN_W = 5,
`else
    parameter int ALU_FUN_W = 4,
`endif
    localparam int CW = (N_INT > 1) ? $clog2(N_INT) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          ir,
    input  logic                 br_eq,
    input  logic                 br_lt,
    input  logic                 br_ltu,
    input  logic [N_INT-1:0]     int_req,
    input  logic                 mie,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ALU_FUN_W-1:0] alu_fun,
    output logic [1:0]           srcA_sel,
    output logic [2:0]           srcB_sel,
    output logic [2:0]           pc_sel,
    output logic [1:0]           rf_sel,
    output logic                 reg_wr,
    output logic                 mem_rd,
    output logic                 mem_we,
    output logic                 illegal,
    output logic                 int_taken,
    output logic [CW-1:0]        int_cause
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic {RUN, IN_ISR} isr_state_t;

    isr_state_t state_q, state_d;
    logic [N_INT-1:0] pend_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       accept;

    logic [ALU_FUN_W-1:0] d_alu;
    logic [1:0] d_srca;
    logic [2:0] d_srcb;
    logic [2:0] d_pc;
    logic [1:0] d_rf;
    logic       d_reg_wr, d_mem_rd, d_mem_we, d_bad, d_mret;

    logic          win_found;
    logic [CW-1:0] win_idx;
    logic          take_int;
    logic [N_INT-1:0] taken_mask;

    // rs1/rs2/rd and immediate fields are not needed to build control signals.
    logic unused_ir;
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    assign opcode   = ir[6:0];
    assign funct3   = ir[14:12];
    assign funct7   = ir[31:25];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // NOTE: every field gets a default before the case so no path leaves a variable unassigned (no latches).
    always_comb begin
        d_alu    = '0;
        d_srca   = '0;
        d_srcb   = '0;
        d_pc     = '0;
        d_rf     = '0;
        d_reg_wr = 1'b0;
        d_mem_rd = 1'b0;
        d_mem_we = 1'b0;
        d_bad    = 1'b0;
        d_mret   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_alu = ALU_FUN_W'(4'd9); d_srca = 2'd1; d_rf = 2'd3; d_reg_wr = 1'b1;
            end
            OPC_AUIPC: begin
                d_srca = 2'd1; d_srcb = 3'd3; d_rf = 2'd3; d_reg_wr = 1'b1;
            end
            OPC_JAL: begin
                d_pc = 3'd3; d_reg_wr = 1'b1;
            end
            OPC_JALR: begin
                d_pc = 3'd1; d_reg_wr = 1'b1;
            end
            OPC_LOAD: begin
                d_srcb = 3'd1; d_rf = 2'd2; d_mem_rd = 1'b1; d_reg_wr = 1'b1;
            end
            OPC_STORE: begin
                d_srcb = 3'd2; d_mem_we = 1'b1;
            end
            OPC_OPIMM: begin
                d_srcb   = 3'd1;
                d_rf     = 2'd3;
                d_reg_wr = 1'b1;
                // Only the shift-right immediate uses ir[30] (SRAI vs SRLI).
                d_alu    = (funct3 == 3'b101) ? ALU_FUN_W'({ir[30], funct3})
                                              : ALU_FUN_W'({1'b0, funct3});
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    d_alu = ALU_FUN_W'({ir[30], funct3}); d_rf = 2'd3; d_reg_wr = 1'b1;
                end
`ifdef OTTER_MDU_EN
                else if (funct7 == 7'b0000001) begin
                    d_alu = ALU_FUN_W'({2'b10, funct3}); d_rf = 2'd3; d_reg_wr = 1'b1;
                end
`endif
                else begin
                    d_bad = 1'b1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  d_pc = br_eq   ? 3'd2 : 3'd0;
                    3'b001:  d_pc = !br_eq  ? 3'd2 : 3'd0;
                    3'b100:  d_pc = br_lt   ? 3'd2 : 3'd0;
                    3'b101:  d_pc = !br_lt  ? 3'd2 : 3'd0;
                    3'b110:  d_pc = br_ltu  ? 3'd2 : 3'd0;
                    3'b111:  d_pc = !br_ltu ? 3'd2 : 3'd0;
                    default: d_pc = 3'd0;
                endcase
            end
            OPC_SYSTEM: begin
                d_rf     = 2'd1;
                d_reg_wr = (funct3 != 3'b000);
                case (funct3)
                    3'b000: begin d_pc = 3'd5; d_mret = 1'b1; end
                    3'b001: d_alu = ALU_FUN_W'(4'd9);
                    3'b010: begin d_srcb = 3'd4; d_alu = ALU_FUN_W'(4'd6); end
                    3'b011: begin d_srca = 2'd2; d_srcb = 3'd4; d_alu = ALU_FUN_W'(4'd7); end
                    default: ;
                endcase
            end
            default: d_bad = 1'b1;
        endcase
        if (d_bad) begin
            d_alu    = '1;
            d_srca   = 2'd3;
            d_srcb   = 3'd7;
            d_pc     = 3'd0;
            d_rf     = 2'd3;
            d_reg_wr = 1'b0;
            d_mem_rd = 1'b0;
            d_mem_we = 1'b0;
        end
    end

    // Lowest pending index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win_found = 1'b1;
                win_idx   = CW'(i);
            end
        end
    end

    assign take_int   = accept && (state_q == RUN) && mie && win_found;
    assign taken_mask = take_int ? (N_INT'(1) << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (take_int) state_d = IN_ISR;
            IN_ISR:  if (accept && d_mret) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= (pend_q & ~taken_mask) | int_req;
        end
    end

    // NOTE: every output flop is reset; an in-flight word must vanish when RST_N drops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            alu_fun   <= '0;
            srcA_sel  <= '0;
            srcB_sel  <= '0;
            pc_sel    <= '0;
            rf_sel    <= '0;
            reg_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            illegal   <= 1'b0;
            int_taken <= 1'b0;
            int_cause <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_fun   <= d_alu;
            srcA_sel  <= d_srca;
            srcB_sel  <= d_srcb;
            pc_sel    <= take_int ? 3'd4 : d_pc;
            rf_sel    <= d_rf;
            reg_wr    <= d_reg_wr && !take_int;
            mem_rd    <= d_mem_rd && !take_int;
            mem_we    <= d_mem_we && !take_int;
            illegal   <= d_bad && !take_int;
            int_taken <= take_int;
            int_cause <= take_int ? win_idx : '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_otter_decode_stage.sv
// Self-checking bench for otter_decode_stage: decode vector table plus handshake,
// interrupt and reset sequences. Honors OTTER_MDU_EN for the MUL encoding.
module tb_otter_decode_stage;

`ifdef OTTER_MDU_EN
    localparam int AW = 5;
`else
    localparam int AW = 4;
`endif

    logic          CLK, RST_N;
    logic          in_valid, in_ready;
    logic [31:0]   ir;
    logic          br_eq, br_lt, br_ltu;
    logic [3:0]    int_req;
    logic          mie, out_ready, out_valid;
    logic [AW-1:0] alu_fun;
    logic [1:0]    srcA_sel, rf_sel;
    logic [2:0]    srcB_sel, pc_sel;
    logic          reg_wr, mem_rd, mem_we, illegal, int_taken;
    logic [1:0]    int_cause;

    otter_decode_stage #(.N_INT(4), .ALU_FUN_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
        .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .int_req(int_req), .mie(mie),
        .out_ready(out_ready), .out_valid(out_valid), .alu_fun(alu_fun),
        .srcA_sel(srcA_sel), .srcB_sel(srcB_sel), .pc_sel(pc_sel), .rf_sel(rf_sel),
        .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_we(mem_we), .illegal(illegal),
        .int_taken(int_taken), .int_cause(int_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  flags;   // {eq, lt, ltu}
        logic [4:0]  alu;
        logic [1:0]  sa;
        logic [2:0]  sb;
        logic [2:0]  pc;
        logic [1:0]  rf;
        logic [3:0]  strb;    // {reg_wr, mem_rd, mem_we, illegal}
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] I_ADD  = 32'h00208133;
    localparam logic [31:0] I_LOAD = 32'h0000A083;
    localparam logic [31:0] I_MRET = 32'h30200073;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] w, input logic [2:0] f, input logic [4:0] alu,
                       input logic [1:0] sa, input logic [2:0] sb, input logic [2:0] pc,
                       input logic [1:0] rf, input logic [3:0] strb);
        vec_t v;
        v.w = w; v.flags = f; v.alu = alu; v.sa = sa; v.sb = sb;
        v.pc = pc; v.rf = rf; v.strb = strb;
        vecs.push_back(v);
    endtask

    // Called just after a falling edge; returns at the next falling edge with the word registered.
    task automatic send(input logic [31:0] w, input logic [2:0] f);
        ir = w;
        {br_eq, br_lt, br_ltu} = f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] mul_alu;
        logic [1:0] mul_sa, mul_rf;
        logic [2:0] mul_sb;
        logic [3:0] mul_strb;

        add(32'h00208133, 3'b000, 5'd0,  2'd0, 3'd0, 3'd0, 2'd3, 4'b1000); // ADD
        add(32'h40208133, 3'b000, 5'd8,  2'd0, 3'd0, 3'd0, 2'd3, 4'b1000); // SUB
        add(32'h4020D133, 3'b000, 5'd13, 2'd0, 3'd0, 3'd0, 2'd3, 4'b1000); // SRA
        add(32'h00500093, 3'b000, 5'd0,  2'd0, 3'd1, 3'd0, 2'd3, 4'b1000); // ADDI
        add(32'h4050D093, 3'b000, 5'd13, 2'd0, 3'd1, 3'd0, 2'd3, 4'b1000); // SRAI
        add(32'h40002093, 3'b000, 5'd2,  2'd0, 3'd1, 3'd0, 2'd3, 4'b1000); // SLTI, ir30 ignored
        add(32'h123450B7, 3'b000, 5'd9,  2'd1, 3'd0, 3'd0, 2'd3, 4'b1000); // LUI
        add(32'h00000097, 3'b000, 5'd0,  2'd1, 3'd3, 3'd0, 2'd3, 4'b1000); // AUIPC
        add(32'h0000006F, 3'b000, 5'd0,  2'd0, 3'd0, 3'd3, 2'd0, 4'b1000); // JAL
        add(32'h00008067, 3'b000, 5'd0,  2'd0, 3'd0, 3'd1, 2'd0, 4'b1000); // JALR
        add(32'h0000A083, 3'b000, 5'd0,  2'd0, 3'd1, 3'd0, 2'd2, 4'b1100); // LW
        add(32'h0010A023, 3'b000, 5'd0,  2'd0, 3'd2, 3'd0, 2'd0, 4'b0010); // SW
        add(32'h00209463, 3'b000, 5'd0,  2'd0, 3'd0, 3'd2, 2'd0, 4'b0000); // BNE taken
        add(32'h00209463, 3'b100, 5'd0,  2'd0, 3'd0, 3'd0, 2'd0, 4'b0000); // BNE not taken
        add(32'h00208463, 3'b100, 5'd0,  2'd0, 3'd0, 3'd2, 2'd0, 4'b0000); // BEQ taken
        add(32'h0020C463, 3'b010, 5'd0,  2'd0, 3'd0, 3'd2, 2'd0, 4'b0000); // BLT taken
        add(32'h0020D463, 3'b010, 5'd0,  2'd0, 3'd0, 3'd0, 2'd0, 4'b0000); // BGE not taken
        add(32'h0020E463, 3'b001, 5'd0,  2'd0, 3'd0, 3'd2, 2'd0, 4'b0000); // BLTU taken
        add(32'h0020F463, 3'b000, 5'd0,  2'd0, 3'd0, 3'd2, 2'd0, 4'b0000); // BGEU taken
        add(32'h0020A463, 3'b111, 5'd0,  2'd0, 3'd0, 3'd0, 2'd0, 4'b0000); // branch f3=010
        add(32'h30509073, 3'b000, 5'd9,  2'd0, 3'd0, 3'd0, 2'd1, 4'b1000); // CSRRW
        add(32'h3050A073, 3'b000, 5'd6,  2'd0, 3'd4, 3'd0, 2'd1, 4'b1000); // CSRRS
        add(32'h3050B073, 3'b000, 5'd7,  2'd2, 3'd4, 3'd0, 2'd1, 4'b1000); // CSRRC
        add(32'h30200073, 3'b000, 5'd0,  2'd0, 3'd0, 3'd5, 2'd1, 4'b0000); // MRET
        add(32'h0000007F, 3'b000, 5'h1F, 2'd3, 3'd7, 3'd0, 2'd3, 4'b0001); // unknown opcode
        add(32'h04208133, 3'b000, 5'h1F, 2'd3, 3'd7, 3'd0, 2'd3, 4'b0001); // OP bad funct7
`ifdef OTTER_MDU_EN
        mul_alu = 5'b10000; mul_sa = 2'd0; mul_sb = 3'd0; mul_rf = 2'd3; mul_strb = 4'b1000;
`else
        mul_alu = 5'h1F; mul_sa = 2'd3; mul_sb = 3'd7; mul_rf = 2'd3; mul_strb = 4'b0001;
`endif
        add(32'h02208133, 3'b000, mul_alu, mul_sa, mul_sb, 3'd0, mul_rf, mul_strb); // MUL

        RST_N = 1'b0; in_valid = 1'b0; ir = '0; br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        int_req = '0; mie = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_out_valid", out_valid, 0);
        check("rst_fields", {alu_fun, srcA_sel, srcB_sel, pc_sel, rf_sel}, 0);
        check("rst_strobes", {reg_wr, mem_rd, mem_we, illegal, int_taken, int_cause}, 0);
        check("rst_in_ready", in_ready, 1);
        RST_N = 1'b1;

        // Decode table
        foreach (vecs[i]) begin
            send(vecs[i].w, vecs[i].flags);
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_alu", i), alu_fun, vecs[i].alu[AW-1:0]);
            check($sformatf("v%0d_srcA", i), srcA_sel, vecs[i].sa);
            check($sformatf("v%0d_srcB", i), srcB_sel, vecs[i].sb);
            check($sformatf("v%0d_pc", i), pc_sel, vecs[i].pc);
            check($sformatf("v%0d_rf", i), rf_sel, vecs[i].rf);
            check($sformatf("v%0d_strobes", i), {reg_wr, mem_rd, mem_we, illegal}, vecs[i].strb);
            check($sformatf("v%0d_int", i), {int_taken, int_cause}, 0);
        end
        idle();
        check("drain_valid", out_valid, 0);

        // Backpressure: ADD held for three stalled cycles while LOAD waits on the input.
        ir = I_ADD; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK);
        #1;
        ir = I_LOAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check($sformatf("stall%0d_in_ready", c), in_ready, 0);
            check($sformatf("stall%0d_hold", c), {out_valid, alu_fun, rf_sel, reg_wr, mem_rd}, {1'b1, AW'(0), 2'd3, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", in_ready, 1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        @(negedge CLK);
        check("unstall_load", {out_valid, rf_sel, mem_rd, srcB_sel}, {1'b1, 2'd2, 1'b1, 3'd1});
        idle();

        // Interrupts: sources 1 and 2 pend; LOAD slot replaced by source 1.
        int_req = 4'b0110;
        @(negedge CLK);
        int_req = 4'b0000;
        mie = 1'b1;
        send(I_LOAD, 3'b000);
        check("int1_taken", int_taken, 1);
        check("int1_cause", int_cause, 1);
        check("int1_pc", pc_sel, 4);
        check("int1_strobes", {reg_wr, mem_rd, mem_we, illegal}, 0);
        send(I_ADD, 3'b000);
        check("isr_no_int", {int_taken, int_cause}, 0);
        check("isr_add_wr", {reg_wr, pc_sel}, {1'b1, 3'd0});
        send(I_MRET, 3'b000);
        check("mret_no_int", int_taken, 0);
        check("mret_pc", pc_sel, 5);
        send(I_ADD, 3'b000);
        check("int2_taken", {int_taken, int_cause, pc_sel, reg_wr}, {1'b1, 2'd2, 3'd4, 1'b0});
        send(I_ADD, 3'b000);
        check("isr2_no_int", int_taken, 0);
        send(I_MRET, 3'b000);

        // A request rising in the accept cycle is only seen by the following accept.
        int_req = 4'b0001;
        send(I_ADD, 3'b000);
        int_req = 4'b0000;
        check("late_req_not_taken", int_taken, 0);
        send(I_ADD, 3'b000);
        check("late_req_taken", {int_taken, int_cause}, {1'b1, 2'd0});
        send(I_MRET, 3'b000);
        mie = 1'b0;
        idle();

        // Reset mid-stall with source 3 pending and masked.
        int_req = 4'b1000;
        ir = I_ADD; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK);
        #1;
        in_valid = 1'b0; int_req = 4'b0000;
        @(negedge CLK);
        check("pre_rst_valid", out_valid, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_fields", {alu_fun, rf_sel, reg_wr}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        mie = 1'b1;
        send(I_ADD, 3'b000);
        check("pend_cleared", int_taken, 0);
        check("post_rst_add", {out_valid, rf_sel, reg_wr}, {1'b1, 2'd3, 1'b1});
        mie = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
